// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-slot anti-ghosting
// dead time, leading-zero blanking and a frame-synchronous load handshake.
module seg7_scan_ctrl #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic        ready,
  output logic        frame_done,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h0C;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    dp_disp_q, dp_disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          frame_end;
  logic          lz_blank;
  logic [3:0]    cur_nib;

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    dp_disp_d    = dp_disp_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;

    frame_end    = en && (cnt_q == CNT_MAX) && (idx_q == 2'd3);
    frame_done_d = frame_end;

    if (!en) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // A pending update lands only at a frame boundary (or immediately when idle);
    // ready is low while pending, so capture and apply never coincide.
    if (pending_q && (frame_end || !en)) begin
      disp_d    = shadow_q;
      dp_disp_d = shadow_dp_q;
      pending_d = 1'b0;
    end else if (load && !pending_q) begin
      shadow_d    = value;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end

    case (idx_q)
      2'd0:    cur_nib = disp_q[3:0];
      2'd1:    cur_nib = disp_q[7:4];
      2'd2:    cur_nib = disp_q[11:8];
      default: cur_nib = disp_q[15:12];
    endcase

    // Digit i is a leading zero when nibbles i..3 are all zero; digit 0 always shows.
    lz_blank = blank_lz && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000);

    if (en && (cnt_q >= CNT_BLANK) && !lz_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_decode(cur_nib);
      dp_d  = ~dp_disp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0000;
      dp_disp_q    <= 4'h0;
      shadow_q     <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      pending_q    <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      dp_disp_q    <= dp_disp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = ~pending_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide parameter CLK_DIV, default 1000: clock cycles per digit slot; legal values are >= BLANK_CYC+2.
REQ-002 The block SHALL provide parameter BLANK_CYC, default 8: anti-ghosting dead cycles at the start of each slot; legal values are >= 1.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: scan enable.
REQ-006 The block SHALL have port load, input, 1 bit: request to update the display value.
REQ-007 The block SHALL have port value, input, 16 bits: four hex nibbles; nibble i maps to digit i, and digit 0 is rightmost.
REQ-008 The block SHALL have port dp_in, input, 4 bits: decimal-point enables, one bit per digit, active-high.
REQ-009 The block SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-010 The block SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame end.
REQ-012 The block SHALL have port an, output, 4 bits: common-anode digit enables, active-low.
REQ-013 The block SHALL have port seg, output, 7 bits: segments, active-low, with seg[6]=a through seg[0]=g.
REQ-014 The block SHALL have port dp, output, 1 bit: decimal-point segment, active-low.

Function
REQ-015 Slot counter cnt SHALL count 0..CLK_DIV-1 while en=1 and wrap to 0. On each wrap, digit index idx SHALL increment 0->1->2->3->0.
REQ-016 A frame SHALL be defined as four slots. The frame-end cycle SHALL be the cycle where en=1, cnt=CLK_DIV-1 and idx=3.
REQ-017 The outputs an, seg, dp and frame_done SHALL be registered. Output values in cycle t+1 SHALL reflect cnt, idx and the display registers in cycle t.
REQ-018 When cnt<BLANK_CYC (dead time), outputs SHALL be an=4'hF, seg=7'h7F, dp=1.
REQ-019 When cnt>=BLANK_CYC, outputs SHALL be an=~(4'b0001<<idx), seg=decode(disp nibble idx), dp=~dp_disp[idx].
REQ-020 The decode mapping 0..F SHALL be: 01,4F,12,06,4C,24,20,0F,00,0C,08,60,31,42,30,38 (hex).
REQ-021 Leading-zero blanking: when blank_lz=1, digit i (i=1..3) SHALL be blanked if disp nibbles i..3 are all zero. Digit 0 SHALL never be blanked.
REQ-022 A blanked digit SHALL output an=4'hF, seg=7'h7F, dp=1 for its whole slot, regardless of dp_disp.
REQ-023 Handshake: load=1 with ready=1 SHALL capture value and dp_in into shadow registers and set pending. ready SHALL read 0 from the next cycle.
REQ-024 load=1 while ready=0 SHALL be ignored; the shadow registers SHALL be unchanged.
REQ-025 At frame end with pending=1: shadow SHALL be copied to disp/dp_disp and pending cleared. ready SHALL read 1 in the next cycle.
REQ-026 Updates SHALL only take effect at frame boundaries, so a frame never shows a mix of old and new digits.
REQ-027 Simultaneous load=1, ready=1 and frame end: the new value SHALL be captured into shadow. It SHALL NOT be applied in that cycle, and SHALL be applied at the next frame end.
REQ-028 frame_done SHALL pulse high for exactly one cycle after every frame-end cycle, independent of pending.
REQ-029 While en=0: cnt and idx SHALL be held at 0, and outputs SHALL be an=4'hF, seg=7'h7F, dp=1, frame_done=0.
REQ-030 While en=0, a pending shadow SHALL be copied to disp on the next cycle, and ready SHALL read 1 one cycle after that.
REQ-031 en falling mid-frame SHALL force cnt=0 and idx=0 on the next cycle. When en rises again, scanning SHALL restart from slot 0, cycle 0.
REQ-032 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-033 rst=1 at a clock edge SHALL set cnt=0, idx=0, disp=16'h0000, dp_disp=0, shadow=0, pending=0, ready=1, frame_done=0, an=4'hF, seg=7'h7F, dp=1.
REQ-034 Reset SHALL take priority over en and load in the same cycle. An in-flight pending update SHALL be discarded.

Verification (CLK_DIV=10, BLANK_CYC=2)
REQ-035 Bench SHALL cover: reset, then en=1, value=16'h0000 -> slot 0: an=F for 2 cycles, then an=4'hE, seg=7'h01 for 8 cycles. Digits 1..3 follow with an=D,B,7, each showing seg=01.
REQ-036 Bench SHALL cover: load with value=16'h12AF, dp_in=4'b0100 mid-frame -> ready=0 next cycle. Old digits persist until frame end. The next frame shows seg=38,08,12,4F for idx 0..3, with dp=0 only in slot 2, and ready=1 after frame end.
REQ-037 Bench SHALL cover: blank_lz=1, value=16'h0050 -> slots 2 and 3 give an=F and seg=7F. Slot 1 shows 24, slot 0 shows 01.
REQ-038 Bench SHALL cover: second load while ready=0 -> ignored; only the first value appears at the next frame.
REQ-039 Bench SHALL cover: load coincident with the frame-end cycle -> frame_done pulses; the value appears one frame later, not in the immediately following frame.
REQ-040 Bench SHALL cover: en dropped at idx=2, cnt=5 -> next cycle an=F, seg=7F. On re-enable, the first active output is an=4'hE after 2 dead cycles. rst asserted while pending -> ready=1, disp=0.
